// File: rtl/pipe_decode_ctrl.sv
// pipe_decode_ctrl: main opcode decoder plus the ID/EX control pipeline register.
// The opcode in ID is decoded combinationally. The control word is registered into EX,
// so all outputs appear one cycle after op.
// Optional macro PIPE_DECODE_EXT_OPS_EN enables andi/ori/slti/lui/bne/jal.
// Without it, those opcodes decode as illegal, and branchne/link stay 0.
//
// Pipeline control semantics, applied on every rising edge in priority order:
//   reset  > flush > stall > load
//   reset : clear the whole register, including illegal_count
//   flush : load a bubble (ex_valid=0, all controls 0), even if stall is also high
//   stall : hold every output, including illegal_count
//   load  : with id_valid=0, load a bubble.
//           With id_valid=1, load the decoded word with ex_valid=1.
//           An illegal opcode also bumps the saturating counter.
module pipe_decode_ctrl #(
  parameter int ALUOP_W = 4,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         op,
  input  logic               id_valid,
  input  logic               stall,
  input  logic               flush,
  output logic               ex_valid,
  output logic               regwritee,
  output logic               memtoreg,
  output logic               memwrite,
  output logic [ALUOP_W-1:0] aluop,
  output logic               alusrc,
  output logic               regdst,
  output logic               branch,
  output logic               branchne,
  output logic               jump,
  output logic               link,
  output logic               illegal,
  output logic [CNT_W-1:0]   illegal_count
);

  // Opcodes
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // ALU operation classes (3 significant bits; wider aluop is zero-filled)
  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_RT  = 3'd2;
  localparam logic [2:0] ALU_AND = 3'd3;
  localparam logic [2:0] ALU_OR  = 3'd4;
  localparam logic [2:0] ALU_SLT = 3'd5;
  localparam logic [2:0] ALU_LUI = 3'd6;

  // One control word, shared by the decoder output and the EX register
  typedef struct packed {
    logic               ex_valid;
    logic               regwritee;
    logic               memtoreg;
    logic               memwrite;
    logic [ALUOP_W-1:0] aluop;
    logic               alusrc;
    logic               regdst;
    logic               branch;
    logic               branchne;
    logic               jump;
    logic               link;
    logic               illegal;
  } ctrl_t;

  ctrl_t            w_ctrl;
  logic [2:0]       w_alu3;
  ctrl_t            r_ctrl;
  logic [CNT_W-1:0] r_illegal_count;

  // Combinational opcode decode. An unknown opcode gives all controls 0 and illegal=1.
  always_comb begin
    w_ctrl          = '0;
    w_ctrl.ex_valid = 1'b1;
    w_alu3          = ALU_ADD;
    case (op)
      OP_LW: begin
        w_ctrl.regwritee = 1'b1;
        w_ctrl.memtoreg  = 1'b1;
        w_ctrl.alusrc    = 1'b1;
      end
      OP_SW: begin
        w_ctrl.memwrite = 1'b1;
        w_ctrl.alusrc   = 1'b1;
      end
      OP_RTYPE: begin
        w_ctrl.regwritee = 1'b1;
        w_ctrl.regdst    = 1'b1;
        w_alu3           = ALU_RT;
      end
      OP_BEQ: begin
        w_ctrl.branch = 1'b1;
        w_alu3        = ALU_SUB;
      end
      OP_ADDI: begin
        w_ctrl.regwritee = 1'b1;
        w_ctrl.alusrc    = 1'b1;
      end
      OP_J: begin
        w_ctrl.jump = 1'b1;
      end
`ifdef PIPE_DECODE_EXT_OPS_EN
      OP_ANDI: begin
        w_ctrl.regwritee = 1'b1;
        w_ctrl.alusrc    = 1'b1;
        w_alu3           = ALU_AND;
      end
      OP_ORI: begin
        w_ctrl.regwritee = 1'b1;
        w_ctrl.alusrc    = 1'b1;
        w_alu3           = ALU_OR;
      end
      OP_SLTI: begin
        w_ctrl.regwritee = 1'b1;
        w_ctrl.alusrc    = 1'b1;
        w_alu3           = ALU_SLT;
      end
      OP_LUI: begin
        w_ctrl.regwritee = 1'b1;
        w_ctrl.alusrc    = 1'b1;
        w_alu3           = ALU_LUI;
      end
      OP_BNE: begin
        w_ctrl.branchne = 1'b1;
        w_alu3          = ALU_SUB;
      end
      OP_JAL: begin
        w_ctrl.jump      = 1'b1;
        w_ctrl.link      = 1'b1;
        w_ctrl.regwritee = 1'b1;
      end
`endif
      default: begin
        w_ctrl.illegal = 1'b1;
      end
    endcase
    w_ctrl.aluop = ALUOP_W'(w_alu3);
  end

  // ID/EX control register and saturating illegal-opcode counter
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ctrl          <= '0;
      r_illegal_count <= '0;
    end else if (flush || (!stall && !id_valid)) begin
      r_ctrl <= '0;
    end else if (!stall) begin
      r_ctrl <= w_ctrl;
      if (w_ctrl.illegal && (r_illegal_count != {CNT_W{1'b1}})) begin
        r_illegal_count <= r_illegal_count + CNT_W'(1);
      end
    end
  end

  assign ex_valid      = r_ctrl.ex_valid;
  assign regwritee     = r_ctrl.regwritee;
  assign memtoreg      = r_ctrl.memtoreg;
  assign memwrite      = r_ctrl.memwrite;
  assign aluop         = r_ctrl.aluop;
  assign alusrc        = r_ctrl.alusrc;
  assign regdst        = r_ctrl.regdst;
  assign branch        = r_ctrl.branch;
  assign branchne      = r_ctrl.branchne;
  assign jump          = r_ctrl.jump;
  assign link          = r_ctrl.link;
  assign illegal       = r_ctrl.illegal;
  assign illegal_count = r_illegal_count;

endmodule

// File: tb/tb_pipe_decode_ctrl.sv
// Testbench for pipe_decode_ctrl.
// The reference model is an opcode->control table plus a small EX-register model.
// Its expectations go through exp_q and are compared one cycle after each drive.
module tb_pipe_decode_ctrl;

  localparam int ALUOP_W = 4;
  localparam int CNT_W   = 2;
  localparam int WORD_W  = 11 + ALUOP_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               reset, id_valid, stall, flush;
  logic [5:0]         op;
  logic               ex_valid, regwritee, memtoreg, memwrite, alusrc, regdst;
  logic               branch, branchne, jump, link, illegal;
  logic [ALUOP_W-1:0] aluop;
  logic [CNT_W-1:0]   illegal_count;

  pipe_decode_ctrl #(.ALUOP_W(ALUOP_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .op(op), .id_valid(id_valid), .stall(stall), .flush(flush),
    .ex_valid(ex_valid), .regwritee(regwritee), .memtoreg(memtoreg), .memwrite(memwrite),
    .aluop(aluop), .alusrc(alusrc), .regdst(regdst), .branch(branch), .branchne(branchne),
    .jump(jump), .link(link), .illegal(illegal), .illegal_count(illegal_count)
  );

  // Observed word, laid out as {ex_valid, regwritee, memtoreg, memwrite, aluop,
  // alusrc, regdst, branch, branchne, jump, link, illegal}
  logic [WORD_W-1:0] obs_word;
  assign obs_word = {ex_valid, regwritee, memtoreg, memwrite, aluop,
                     alusrc, regdst, branch, branchne, jump, link, illegal};

  // ---------------- reference model ----------------
  logic [WORD_W-1:0] legal_tbl [logic [5:0]];
  logic [WORD_W-1:0] m_word;
  int                m_cnt;
  int                cnt_max;

  function automatic logic [WORD_W-1:0] mk(input bit rw, input bit mr, input bit mw,
                                            input int alu, input bit as, input bit rd,
                                            input bit br, input bit bn, input bit j,
                                            input bit lk);
    logic [ALUOP_W-1:0] a;
    a = ALUOP_W'(alu);
    return {1'b1, rw, mr, mw, a, as, rd, br, bn, j, lk, 1'b0};
  endfunction

  function automatic logic [WORD_W-1:0] illegal_word();
    logic [WORD_W-1:0] w;
    w = '0;
    w[WORD_W-1] = 1'b1;
    w[0] = 1'b1;
    return w;
  endfunction

  initial begin
    cnt_max = (1 << CNT_W) - 1;
    legal_tbl[6'b100011] = mk(1, 1, 0, 0, 1, 0, 0, 0, 0, 0); // lw
    legal_tbl[6'b101011] = mk(0, 0, 1, 0, 1, 0, 0, 0, 0, 0); // sw
    legal_tbl[6'b000000] = mk(1, 0, 0, 2, 0, 1, 0, 0, 0, 0); // R-type
    legal_tbl[6'b000100] = mk(0, 0, 0, 1, 0, 0, 1, 0, 0, 0); // beq
    legal_tbl[6'b001000] = mk(1, 0, 0, 0, 1, 0, 0, 0, 0, 0); // addi
    legal_tbl[6'b000010] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0); // j
`ifdef PIPE_DECODE_EXT_OPS_EN
    legal_tbl[6'b001100] = mk(1, 0, 0, 3, 1, 0, 0, 0, 0, 0); // andi
    legal_tbl[6'b001101] = mk(1, 0, 0, 4, 1, 0, 0, 0, 0, 0); // ori
    legal_tbl[6'b001010] = mk(1, 0, 0, 5, 1, 0, 0, 0, 0, 0); // slti
    legal_tbl[6'b001111] = mk(1, 0, 0, 6, 1, 0, 0, 0, 0, 0); // lui
    legal_tbl[6'b000101] = mk(0, 0, 0, 1, 0, 0, 0, 1, 0, 0); // bne
    legal_tbl[6'b000011] = mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 1); // jal
`endif
  end

  // ---------------- scoreboard ----------------
  logic [WORD_W-1:0] exp_q[$];
  logic [CNT_W-1:0]  exp_cnt_q[$];
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- driver ----------------
  // Drive one cycle of inputs, advance the model, then check the registered outputs just after the edge.
  task automatic cycle(input string tag, input bit r, input bit f, input bit s,
                       input bit v, input logic [5:0] o);
    logic [WORD_W-1:0] ew;
    logic [CNT_W-1:0]  ec;
    reset = r; flush = f; stall = s; id_valid = v; op = o;
    if (r) begin
      m_word = '0;
      m_cnt  = 0;
    end else if (f || (!s && !v)) begin
      m_word = '0;
    end else if (!s) begin
      if (legal_tbl.exists(o)) m_word = legal_tbl[o];
      else begin
        m_word = illegal_word();
        if (m_cnt < cnt_max) m_cnt++;
      end
    end
    exp_q.push_back(m_word);
    exp_cnt_q.push_back(CNT_W'(m_cnt));
    @(posedge clk);
    #1;
    ew = exp_q.pop_front();
    ec = exp_cnt_q.pop_front();
    check({tag, "_word"}, 32'(obs_word), 32'(ew));
    check({tag, "_cnt"}, 32'(illegal_count), 32'(ec));
  endtask

  // ---------------- stimulus ----------------
  logic [5:0] op_pool [16];

  initial begin
    op_pool = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010,
                6'b001100, 6'b001101, 6'b001010, 6'b001111, 6'b000101, 6'b000011,
                6'b111111, 6'b010101, 6'b100011, 6'b000000};
    m_word = '0;
    m_cnt  = 0;
    reset = 1'b1; flush = 1'b0; stall = 1'b0; id_valid = 1'b0; op = '0;

    // Reset with a live lw on the input, then release
    cycle("rst0", 1, 0, 0, 1, 6'b100011);
    cycle("rst1", 1, 0, 0, 1, 6'b100011);
    check("rst_all_zero", 32'(obs_word), 32'd0);
    cycle("rel_lw", 0, 0, 0, 1, 6'b100011);
    check("rel_memtoreg", 32'(memtoreg), 32'd1);
    check("rel_ex_valid", 32'(ex_valid), 32'd1);

    // Decode sweep with one-cycle latency
    cycle("dec_lw", 0, 0, 0, 1, 6'b100011);
    check("dec_lw_aluop", 32'(aluop), 32'd0);
    cycle("dec_sw", 0, 0, 0, 1, 6'b101011);
    check("dec_sw_memwrite", 32'(memwrite), 32'd1);
    cycle("dec_rt", 0, 0, 0, 1, 6'b000000);
    check("dec_rt_aluop", 32'(aluop), 32'd2);
    cycle("dec_beq", 0, 0, 0, 1, 6'b000100);
    check("dec_beq_aluop", 32'(aluop), 32'd1);
    cycle("dec_addi", 0, 0, 0, 1, 6'b001000);
    cycle("dec_j", 0, 0, 0, 1, 6'b000010);
    check("dec_j_jump", 32'(jump), 32'd1);

    // Stall hold: beq held through 3 stalled cycles with addi waiting
    cycle("st_beq", 0, 0, 0, 1, 6'b000100);
    for (int i = 0; i < 3; i++) begin
      cycle("st_hold", 0, 0, 1, 1, 6'b001000);
      check("st_branch", 32'(branch), 32'd1);
    end
    cycle("st_release", 0, 0, 0, 1, 6'b001000);

    // Flush wins over stall
    cycle("fl_prio", 0, 1, 1, 1, 6'b100011);
    check("fl_ex_valid", 32'(ex_valid), 32'd0);

    // Illegal opcode and counter saturation (CNT_W=2)
    for (int i = 0; i < 5; i++) begin
      cycle("ill_sat", 0, 0, 0, 1, 6'b111111);
      check("ill_cnt_const", 32'(illegal_count), (i < 3) ? 32'(i + 1) : 32'd3);
    end
    cycle("rst_mid", 1, 1, 1, 1, 6'b111111);
    cycle("ill_one", 0, 0, 0, 1, 6'b111111);
    cycle("ill_novalid", 0, 0, 0, 0, 6'b111111);
    cycle("ill_stall", 0, 0, 1, 1, 6'b111111);
    check("ill_nocount", 32'(illegal_count), 32'd1);

    // jal: legal with the extension, illegal otherwise
    cycle("ext_jal", 0, 0, 0, 1, 6'b000011);
`ifdef PIPE_DECODE_EXT_OPS_EN
    check("ext_jal_link", 32'(link), 32'd1);
`else
    check("ext_jal_illegal", 32'(illegal), 32'd1);
`endif

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      cycle("rnd",
            ($urandom_range(0, 99) < 2),
            ($urandom_range(0, 99) < 10),
            ($urandom_range(0, 99) < 25),
            ($urandom_range(0, 99) < 85),
            ($urandom_range(0, 3) == 0) ? 6'($urandom) : op_pool[$urandom_range(0, 15)]);
    end

    // ---------------- report ----------------
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
